// File: rtl/mx_arith_pkg.sv
// Shared fixed-point arithmetic helpers for the log2 pipeline and the companion antilog LUT.
// Holds the default ROM address width, the ROM-entry generator and the saturation bounds.
package mx_arith_pkg;

  localparam int MX_LUT_W = 6;

  // Working precision of the repeated-squaring log2 evaluation.
  localparam int LOG2_PREC = 60;

  // round-half-up(log2(1 + idx/2^lut_w) * 2^f). First the f+1 fraction bits of
  // log2 are extracted by repeated squaring, then the extra bit is used for rounding.
  function automatic int log2_frac_entry(input int idx, input int lut_w, input int f);
    logic [127:0] y;
    int           acc;
    y   = 128'(idx + (1 << lut_w)) << (LOG2_PREC - lut_w);
    acc = 0;
    for (int k = 0; k <= f; k++) begin
      y   = (y * y) >> LOG2_PREC;
      acc = acc << 1;
      if (y[LOG2_PREC+1]) begin
        acc = acc | 1;
        y   = y >> 1;
      end
    end
    return (acc + 1) >>> 1;
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/log2_frac_lut.sv
// Combinational fraction ROM: log2(1 + addr/2^LUT_W) scaled by 2^F.
// Contents are computed at elaboration from the shared package generator.
module log2_frac_lut
  import mx_arith_pkg::*;
#(
  parameter int LUT_W = MX_LUT_W,
  parameter int F     = 4
) (
  input  logic [LUT_W-1:0] i_addr,
  output logic [F:0]       o_frac
);

  // One extra bit: entries near the top of the mantissa range round up to 2^F.
  logic [F:0] w_rom [2**LUT_W];

  for (genvar g = 0; g < 2**LUT_W; g++) begin : g_rom
    assign w_rom[g] = (F+1)'(log2_frac_entry(g, LUT_W, F));
  end

  assign o_frac = w_rom[i_addr];

endmodule

// File: rtl/mx_log2_pipe.sv
// Three-stage log2 pipeline for unsigned fixed-point input with valid/ready flow control:
// S1 leading-one detect + mantissa extract, S2 fraction ROM lookup, S3 assemble and saturate.
module mx_log2_pipe
  import mx_arith_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 10,
  parameter int DATA_IN_0_PRECISION_1  = 8,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 4,
  parameter int LUT_W                  = MX_LUT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_zero,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int W_IN    = DATA_IN_0_PRECISION_0;
  localparam int FRAC_IN = DATA_IN_0_PRECISION_1;
  localparam int W_OUT   = DATA_OUT_0_PRECISION_0;
  localparam int F       = DATA_OUT_0_PRECISION_1;
  localparam int PW      = $clog2(W_IN);
  localparam int FW      = (PW > $clog2(FRAC_IN + 1)) ? PW : $clog2(FRAC_IN + 1);
  localparam int AW_MIN  = FW + F + 3;
  localparam int AW      = (AW_MIN > W_OUT + 1) ? AW_MIN : W_OUT + 1;

  localparam logic signed [AW-1:0] SAT_HI = AW'(sat_hi(W_OUT));
  localparam logic signed [AW-1:0] SAT_LO = AW'(sat_lo(W_OUT));
  localparam logic signed [AW-1:0] FRAC_S = AW'(FRAC_IN);

  logic w_ld1, w_ld2, w_ld3;

  logic [PW-1:0]    w_p;
  logic             w_zero;
  logic [LUT_W-1:0] w_addr;

  logic             r1_valid;
  logic             r1_zero;
  logic [PW-1:0]    r1_p;
  logic [LUT_W-1:0] r1_addr;

  logic [F:0]       w_frac;

  logic             r2_valid;
  logic             r2_zero;
  logic [PW-1:0]    r2_p;
  logic [F:0]       r2_frac;

  logic signed [AW-1:0] w_exp;
  logic signed [AW-1:0] w_sum;
  logic [W_OUT-1:0]     w_res;

  logic             r3_valid;
  logic             r3_zero;
  logic [W_OUT-1:0] r3_data;

  // A stage may load when empty or when its occupant moves on this same cycle.
  assign w_ld3           = !r3_valid || data_out_0_ready;
  assign w_ld2           = !r2_valid || w_ld3;
  assign w_ld1           = !r1_valid || w_ld2;
  assign data_in_0_ready = w_ld1;

  always_comb begin
    // NOTE: default before the loop so no path leaves w_p unassigned (no latch).
    w_p = '0;
    for (int i = 0; i < W_IN; i++) begin
      if (data_in_0[i]) w_p = PW'(i);
    end
  end

  assign w_zero = (data_in_0 == '0);

  // Bits directly below the leading one, MSB first; missing positions read as 0.
  always_comb begin
    w_addr = '0;
    for (int k = 0; k < LUT_W; k++) begin
      if (int'(w_p) > k) w_addr[LUT_W-1-k] = data_in_0[w_p - PW'(k) - PW'(1)];
    end
  end

  // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
  // NOTE: datapath registers are reset too, so outputs read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_zero  <= 1'b0;
      r1_p     <= '0;
      r1_addr  <= '0;
    end else if (w_ld1) begin
      r1_valid <= data_in_0_valid;
      if (data_in_0_valid) begin
        r1_zero <= w_zero;
        r1_p    <= w_p;
        r1_addr <= w_addr;
      end
    end
  end

  log2_frac_lut #(
    .LUT_W (LUT_W),
    .F     (F)
  ) u_lut (
    .i_addr (r1_addr),
    .o_frac (w_frac)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_zero  <= 1'b0;
      r2_p     <= '0;
      r2_frac  <= '0;
    end else if (w_ld2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_zero <= r1_zero;
        r2_p    <= r1_p;
        r2_frac <= w_frac;
      end
    end
  end

  assign w_exp = $signed(AW'(r2_p)) - FRAC_S;
  assign w_sum = (w_exp <<< F) + $signed(AW'(r2_frac));

  always_comb begin
    w_res = w_sum[W_OUT-1:0];
    if (r2_zero)             w_res = SAT_LO[W_OUT-1:0];
    else if (w_sum > SAT_HI) w_res = SAT_HI[W_OUT-1:0];
    else if (w_sum < SAT_LO) w_res = SAT_LO[W_OUT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_zero  <= 1'b0;
      r3_data  <= '0;
    end else if (w_ld3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_zero <= r2_zero;
        r3_data <= w_res;
      end
    end
  end

  assign data_out_0       = r3_data;
  assign data_out_0_zero  = r3_zero;
  assign data_out_0_valid = r3_valid;

endmodule

// File: tb/tb_mx_log2_pipe.sv
// Scoreboard bench for mx_log2_pipe: directed hand-computed vectors, stall, reset, random stream.
module tb_mx_log2_pipe;

  logic       clk;
  logic       rst_n;
  logic [9:0] data_in_0;
  logic       data_in_0_valid;
  logic       data_in_0_ready;
  logic [7:0] data_out_0;
  logic       data_out_0_zero;
  logic       data_out_0_valid;
  logic       data_out_0_ready;

  typedef struct {
    logic [7:0] d;
    logic       z;
    bit         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_rdy = 0;

  mx_log2_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_zero  (data_out_0_zero),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference from real-valued log2, independent of the integer ROM generator.
  function automatic logic [8:0] model(input logic [9:0] x);
    int  p;
    int  a;
    int  pos;
    int  rom;
    int  r;
    real v;
    if (x == 10'd0) return {1'b1, 8'h80};
    p = 0;
    for (int i = 0; i < 10; i++) if (x[i]) p = i;
    a = 0;
    for (int k = 0; k < 6; k++) begin
      pos = p - 1 - k;
      a   = a * 2 + ((pos >= 0) ? int'(x[pos]) : 0);
    end
    v   = $ln(1.0 + real'(a) / 64.0) / $ln(2.0) * 16.0;
    rom = int'($floor(v + 0.5));
    r   = (p - 8) * 16 + rom;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return {1'b0, 8'(r)};
  endfunction

  task automatic send(input logic [9:0] x, input logic [7:0] ed, input logic ez, input bit lat);
    exp_t e;
    bit   ok;
    data_in_0       = x;
    data_in_0_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (data_in_0_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: x=0x%0h never accepted, required accept within 500 cycles", x);
    end else begin
      e.d = ed; e.z = ez; e.lat = lat; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: pops on each output handshake and checks hold-stability while stalled.
  initial begin
    logic [7:0] held_d;
    logic       held_z;
    bit         holding;
    exp_t       e;
    holding = 0;
    held_d  = '0;
    held_z  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holding = 0;
      end else if (data_out_0_valid) begin
        if (holding) begin
          check("stall_data_stable", 32'(data_out_0), 32'(held_d));
          check("stall_zero_stable", 32'(data_out_0_zero), 32'(held_z));
        end
        if (data_out_0_ready) begin
          holding = 0;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, required no output", data_out_0);
          end else begin
            e = q.pop_front();
            check("out_data", 32'(data_out_0), 32'(e.d));
            check("out_zero", 32'(data_out_0_zero), 32'(e.z));
            if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
          end
        end else begin
          holding = 1;
          held_d  = data_out_0;
          held_z  = data_out_0_zero;
        end
      end else begin
        holding = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) data_out_0_ready = ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [9:0] x;
    logic [7:0] d;
    logic       z;
  } vec_t;

  vec_t vecs[11] = '{
    '{10'h100, 8'h00, 1'b0},
    '{10'h200, 8'h10, 1'b0},
    '{10'h180, 8'h09, 1'b0},
    '{10'h3FF, 8'h20, 1'b0},
    '{10'h001, 8'h80, 1'b0},
    '{10'h000, 8'h80, 1'b1},
    '{10'h080, 8'hF0, 1'b0},
    '{10'h0C0, 8'hF9, 1'b0},
    '{10'h002, 8'h90, 1'b0},
    '{10'h003, 8'h99, 1'b0},
    '{10'h300, 8'h19, 1'b0}
  };

  initial begin
    logic [8:0] m;
    logic [9:0] x;
    int         gap;
    rst_n            = 1'b0;
    data_in_0        = '0;
    data_in_0_valid  = 1'b0;
    data_out_0_ready = 1'b1;

    #3;
    check("rst_valid", 32'(data_out_0_valid), 32'd0);
    check("rst_data",  32'(data_out_0), 32'd0);
    check("rst_zero",  32'(data_out_0_zero), 32'd0);
    check("rst_ready", 32'(data_in_0_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(data_in_0_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time so each latency is measured unobstructed.
    foreach (vecs[i]) begin
      send(vecs[i].x, vecs[i].d, vecs[i].z, 1'b1);
      idle(4);
    end

    // Back-to-back stream into a stalled output.
    data_out_0_ready = 1'b0;
    send(10'h100, 8'h00, 1'b0, 1'b0);
    send(10'h200, 8'h10, 1'b0, 1'b0);
    send(10'h180, 8'h09, 1'b0, 1'b0);
    check("full_ready_low", 32'(data_in_0_ready), 32'd0);
    idle(3);
    check("full_ready_still_low", 32'(data_in_0_ready), 32'd0);
    data_out_0_ready = 1'b1;
    idle(6);

    // Mid-stream reset with two operands in flight.
    data_out_0_ready = 1'b0;
    send(10'h200, 8'h10, 1'b0, 1'b0);
    send(10'h3FF, 8'h20, 1'b0, 1'b0);
    idle(2);
    check("inflight_valid", 32'(data_out_0_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_rst_valid", 32'(data_out_0_valid), 32'd0);
    check("async_rst_data",  32'(data_out_0), 32'd0);
    check("async_rst_ready", 32'(data_in_0_ready), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    data_out_0_ready = 1'b1;
    idle(8);
    send(10'h180, 8'h09, 1'b0, 1'b1);
    idle(5);

    // Random stream against the real-valued model.
    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      idle(gap);
      x = ($urandom_range(0, 31) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      m = model(x);
      send(x, m[7:0], m[8], 1'b0);
    end
    rand_rdy = 0;
    @(posedge clk);
    #1;
    data_out_0_ready = 1'b1;

    for (int t = 0; t < 1000 && q.size() != 0; t++) @(negedge clk);
    idle(4);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
